operand_unpack: RTL and testbench
=================================

// Module: operand_unpack
// PURPOSE
//  Front end of the IEEE-754 half-precision adder. Accepts two packed 16-bit
//  operands and splits each into sign, exponent and mantissa with the hidden
//  bit restored. Orders the operands by magnitude and aligns the smaller
//  mantissa with a serial right shifter, one bit per cycle. Outputs
//  exp/Am/Bm/As/Bs/swap/arround feed the adder core and the result-packing
//  stage.
// PARAMETERS
//  MAX_SHIFT  12  alignment shift cap; shifts of MAX_SHIFT or more zero Bm
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous reset, active-high
//  start      in   1   operand valid; accepted only when ready=1
//  A          in   16  operand A {sign,exp[4:0],frac[9:0]}
//  B          in   16  operand B, same format
//  ready      out  1   block idle, start will be accepted
//  out_valid  out  1   aligned result valid, held until out_ack
//  out_ack    in   1   consumer takes the result
//  exp        out  5   effective exponent of the larger operand
//  Am         out  11  larger mantissa {hidden,frac}
//  Bm         out  11  smaller mantissa, right-aligned to exp
//  As         out  1   sign of A (raw, not swapped)
//  Bs         out  1   sign of B (raw, not swapped)
//  swap       out  1   1: B has the larger magnitude (Am comes from B)
//  arround    out  1   guard bit, the last bit shifted out of Bm
//  sticky     out  1   OR of all shifted-out bits except the guard bit
//                      (present only with STICKY_EN)
// BEHAVIOUR
//  - Reset: state IDLE, ready=1, out_valid=0; exp, Am, Bm, As, Bs, swap,
//    arround and sticky all 0. Reset during any state aborts the operation.
//  - Field decode: hidden bit = |exp_field.
//  - Field decode: effective exponent = (exp_field==0) ? 1 : exp_field, so
//    denormals align correctly.
//  - swap = ({B[14:10],B[9:0]} > {A[14:10],A[9:0]}). On equal magnitude,
//    swap=0.
//  - diff = eL - eS, range 0..29. Shift count n = min(diff, MAX_SHIFT).
//  - FSM IDLE: ready=1. start=1 captures A and B, goes to LOAD, ready=0.
//  - FSM LOAD (1 cycle): decode fields, compare magnitudes, load the shifter
//    and the down-counter with n.
//    n==0 -> DONE, otherwise -> ALIGN.
//  - FSM ALIGN: each cycle Bm <= Bm>>1; arround <= bit shifted out;
//    sticky |= old arround; counter decrements. counter reaching 0 -> DONE.
//  - FSM DONE: out_valid=1 and all outputs held stable.
//    out_ack=1 -> IDLE, out_valid=0 and ready=1 on the next cycle.
//  - Latency: out_valid rises n+2 cycles after the start-acceptance edge.
//    Range is 2..MAX_SHIFT+2.
//  - start while ready=0 is ignored; operands are not re-captured.
//  - out_ack outside DONE is ignored.
//  - Throughput: one operation per n+3 cycles. There is no overlap of
//    out_ack with a new start in the same cycle.
//  - Outputs change only in LOAD/ALIGN and are stable for the whole time
//    out_valid=1.
// CONFIGURATION
//  STICKY_EN defined:
//   - sticky port and accumulator are present.
//   - sticky is cleared in LOAD.
//   - When diff > MAX_SHIFT, sticky also ORs the bits that are never shifted
//     (sticky = |Bm_original, minus the guard bit).
//  STICKY_EN undefined:
//   - sticky port and logic are absent.
//   - All other behaviour is identical.
// TESTING
//  1. A=3C00,B=3C00 -> swap=0, exp=15, Am=400, Bm=400, arround=0,
//     out_valid at +2.
//  2. A=3C00,B=4000 -> swap=1, exp=16, Am=400, Bm=200, arround=0,
//     out_valid at +3.
//  3. A=3C01,B=4400 -> swap=1, exp=17, Am=400, Bm=100, arround=0, sticky=1,
//     out_valid at +4.
//  4. A=7800,B=0001 (denormal) -> swap=0, exp=30, Bm=000, arround=0,
//     sticky=1, out_valid at +14.
//  5. rst=1 in the 2nd ALIGN cycle, start held high throughout ->
//     - next cycle: ready=1, out_valid=0, all outputs 0;
//     - start held high is then accepted again.
//  6. In DONE, out_ack=0 for 5 cycles with start pulsed ->
//     - outputs stable, start ignored;
//     - out_ack=1 -> ready=1 the next cycle.

Source files
------------

// File: rtl/operand_unpack.sv
// Half-precision adder front end: unpack, magnitude order, serial align.
// Optional STICKY_EN adds the sticky port and accumulator.
module operand_unpack #(
   parameter int MAX_SHIFT = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        ready,
   output logic        out_valid,
   input  logic        out_ack,
   output logic [4:0]  exp,
   output logic [10:0] Am,
   output logic [10:0] Bm,
   output logic        As,
   output logic        Bs,
   output logic        swap,
   output logic        arround
`ifdef STICKY_EN
   ,
   output logic        sticky
`endif
);

   localparam int CW = $clog2(MAX_SHIFT + 1);
   localparam logic [4:0] MAXS = 5'(MAX_SHIFT);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ALIGN,
      DONE
   } state_t;

   state_t state;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [CW-1:0] cnt;

   logic [4:0]  ea;
   logic [4:0]  eb;
   logic [10:0] ma;
   logic [10:0] mb;
   logic        sw;
   logic [4:0]  el;
   logic [4:0]  es;
   logic [10:0] ml;
   logic [10:0] ms;
   logic [4:0]  diff;
   logic [CW-1:0] n;

   // Denormals use an effective exponent of 1 and no hidden bit.
   always_comb begin
      ea   = (a_q[14:10] == 5'd0) ? 5'd1 : a_q[14:10];
      eb   = (b_q[14:10] == 5'd0) ? 5'd1 : b_q[14:10];
      ma   = {|a_q[14:10], a_q[9:0]};
      mb   = {|b_q[14:10], b_q[9:0]};
      sw   = (b_q[14:0] > a_q[14:0]);
      el   = sw ? eb : ea;
      es   = sw ? ea : eb;
      ml   = sw ? mb : ma;
      ms   = sw ? ma : mb;
      diff = el - es;
      n    = (diff > MAXS) ? CW'(MAXS) : CW'(diff);
   end

`ifdef STICKY_EN
   // Bits above the shift cap never leave Bm; fold them in up front.
   logic rem;
   always_comb begin
      rem = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (i >= MAX_SHIFT) rem = rem | ms[i];
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         cnt       <= '0;
         ready     <= 1'b1;
         out_valid <= 1'b0;
         exp       <= '0;
         Am        <= '0;
         Bm        <= '0;
         As        <= 1'b0;
         Bs        <= 1'b0;
         swap      <= 1'b0;
         arround   <= 1'b0;
`ifdef STICKY_EN
         sticky    <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_q   <= A;
                  b_q   <= B;
                  ready <= 1'b0;
                  state <= LOAD;
               end
            end
            LOAD: begin
               exp     <= el;
               Am      <= ml;
               Bm      <= ms;
               As      <= a_q[15];
               Bs      <= b_q[15];
               swap    <= sw;
               arround <= 1'b0;
               cnt     <= n;
`ifdef STICKY_EN
               sticky  <= (diff > MAXS) ? rem : 1'b0;
`endif
               if (n == '0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end else begin
                  state <= ALIGN;
               end
            end
            ALIGN: begin
               Bm      <= {1'b0, Bm[10:1]};
               arround <= Bm[0];
`ifdef STICKY_EN
               sticky  <= sticky | arround;
`endif
               cnt     <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ack) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  ready     <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_unpack.sv
// Directed bench for operand_unpack: vector table plus reset/hold sequences.
module tb_operand_unpack;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        ready;
   logic        out_valid;
   logic        out_ack;
   logic [4:0]  exp;
   logic [10:0] Am;
   logic [10:0] Bm;
   logic        As;
   logic        Bs;
   logic        swap;
   logic        arround;
`ifdef STICKY_EN
   logic        sticky;
`endif

   operand_unpack dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .A(A),
      .B(B),
      .ready(ready),
      .out_valid(out_valid),
      .out_ack(out_ack),
      .exp(exp),
      .Am(Am),
      .Bm(Bm),
      .As(As),
      .Bs(Bs),
      .swap(swap),
      .arround(arround)
`ifdef STICKY_EN
      ,
      .sticky(sticky)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sw;
      logic [4:0]  ex;
      logic [10:0] am;
      logic [10:0] bm;
      logic        ar;
      logic        st;
      int          lat;
   } vec_t;

   vec_t vecs[10];
   int total = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Launch one operation; returns cycles to out_valid (acceptance = 1).
   task automatic launch(input logic [15:0] a, input logic [15:0] b,
                         output int lat);
      int guard;
      guard = 0;
      while (!ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("ready_before_start", 32'(ready), 32'd1);
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      guard = 0;
      while (!out_valid && guard < 40) begin
         @(posedge clk); #1;
         lat++;
         guard++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic do_ack();
      @(negedge clk);
      out_ack = 1'b1;
      @(posedge clk); #1;
      out_ack = 1'b0;
      chk("ack_ready", 32'(ready), 32'd1);
      chk("ack_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, 32'(ready), 32'd1);
      chk({tag, "_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_outs"}, {exp, Am, Bm, As, Bs, swap, arround}, 32'd0);
`ifdef STICKY_EN
      chk({tag, "_sticky"}, 32'(sticky), 32'd0);
`endif
   endtask

   initial begin
      int lat;
      vecs[0] = '{16'h3C00, 16'h3C00, 1'b0, 5'd15, 11'h400, 11'h400, 1'b0, 1'b0, 2};
      vecs[1] = '{16'h3C00, 16'h4000, 1'b1, 5'd16, 11'h400, 11'h200, 1'b0, 1'b0, 3};
      vecs[2] = '{16'h3C01, 16'h4400, 1'b1, 5'd17, 11'h400, 11'h100, 1'b0, 1'b1, 4};
      vecs[3] = '{16'h7800, 16'h0001, 1'b0, 5'd30, 11'h400, 11'h000, 1'b0, 1'b1, 14};
      vecs[4] = '{16'hC000, 16'h3800, 1'b0, 5'd16, 11'h400, 11'h100, 1'b0, 1'b0, 4};
      vecs[5] = '{16'h0001, 16'h0003, 1'b1, 5'd1,  11'h003, 11'h001, 1'b0, 1'b0, 2};
      vecs[6] = '{16'h4C00, 16'h3FFF, 1'b0, 5'd19, 11'h400, 11'h07F, 1'b1, 1'b1, 6};
      vecs[7] = '{16'h6000, 16'h3000, 1'b0, 5'd24, 11'h400, 11'h000, 1'b0, 1'b1, 14};
      vecs[8] = '{16'h5C00, 16'h3000, 1'b0, 5'd23, 11'h400, 11'h000, 1'b1, 1'b0, 13};
      vecs[9] = '{16'h8400, 16'hBC00, 1'b1, 5'd15, 11'h400, 11'h000, 1'b0, 1'b1, 14};

      rst = 1'b1;
      start = 1'b0;
      out_ack = 1'b0;
      A = '0;
      B = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         launch(vecs[i].a, vecs[i].b, lat);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d_swap", i), 32'(swap), 32'(vecs[i].sw));
         chk($sformatf("v%0d_exp", i), 32'(exp), 32'(vecs[i].ex));
         chk($sformatf("v%0d_Am", i), 32'(Am), 32'(vecs[i].am));
         chk($sformatf("v%0d_Bm", i), 32'(Bm), 32'(vecs[i].bm));
         chk($sformatf("v%0d_As", i), 32'(As), 32'(vecs[i].a[15]));
         chk($sformatf("v%0d_Bs", i), 32'(Bs), 32'(vecs[i].b[15]));
         chk($sformatf("v%0d_arround", i), 32'(arround), 32'(vecs[i].ar));
`ifdef STICKY_EN
         chk($sformatf("v%0d_sticky", i), 32'(sticky), 32'(vecs[i].st));
`endif
         do_ack();
      end

      // Reset in the second ALIGN cycle with start held high.
      @(negedge clk);
      A = 16'h7800;
      B = 16'h0001;
      start = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      A = 16'h3C00;
      B = 16'h4000;
      @(posedge clk); #1;
      chk("rerun_accept", 32'(ready), 32'd0);
      start = 1'b0;
      lat = 1;
      for (int g = 0; g < 40 && !out_valid; g++) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("rerun_lat", 32'(lat), 32'd3);
      chk("rerun_Bm", 32'(Bm), 32'h200);
      chk("rerun_swap", 32'(swap), 32'd1);
      do_ack();

      // Hold in DONE without ack; a start pulse must be ignored.
      launch(16'h4C00, 16'h3FFF, lat);
      chk("hold_lat", 32'(lat), 32'd6);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         start = (c == 1);
         A = 16'h1234;
         B = 16'h5678;
         @(posedge clk); #1;
         chk($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
         chk($sformatf("hold%0d_ready", c), 32'(ready), 32'd0);
         chk($sformatf("hold%0d_outs", c),
             {exp, Am, Bm, As, Bs, swap, arround},
             {5'd19, 11'h400, 11'h07F, 1'b0, 1'b0, 1'b0, 1'b1});
      end
      start = 1'b0;
      do_ack();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got 0, expected 1");
      $fatal(1);
   end

endmodule
